// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Purpose  : Shares one I2C controller between NUM_REQ requesters. Picks a
//            requester round-robin, presents its address/direction/command/
//            data to the controller, fires a one-cycle start, waits for the
//            controller's data_valid and returns a one-cycle done pulse with
//            the read byte and ACK.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in, rst_in          : clock (rising edge), async active-high reset
//   req_in   [N]            : per-requester level request, held until done
//   addr_in  [7N]           : 7-bit peripheral address, slice i = [7i+6:7i]
//   rw_in    [N]            : per-requester direction, 1 = read
//   cmd_in   [8N]           : per-requester command/register byte
//   wdata_in [8N]           : per-requester write data byte
//   grant_out[N]            : one-hot current owner of the controller
//   done_out [N]            : one-cycle completion pulse to the owner
//   rdata_out, ack_out      : read byte / ACK of last completed transaction
//   err_out                 : last completed transaction timed out
//   busy_out                : arbiter not idle
//   start_out, peripheral_addr_out, rw_out, command_byte_out,
//   data_byte_out           : toward the I2C controller
//   data_byte_in, ack_in,
//   data_valid_in           : from the I2C controller
// Configuration
//   I2C_ARB_TIMEOUT_EN      : when defined, a WAIT watchdog of TIMEOUT_CYCLES
//                             cycles ends a stuck transaction with err_out=1.
//                             When undefined, WAIT is unbounded and err_out
//                             is tied low.
// ============================================================================
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic [7*NUM_REQ-1:0] addr_in,
  input  logic [NUM_REQ-1:0]   rw_in,
  input  logic [8*NUM_REQ-1:0] cmd_in,
  input  logic [8*NUM_REQ-1:0] wdata_in,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic [NUM_REQ-1:0]   done_out,
  output logic [7:0]           rdata_out,
  output logic                 ack_out,
  output logic                 err_out,
  output logic                 busy_out,
  output logic                 start_out,
  output logic [6:0]           peripheral_addr_out,
  output logic                 rw_out,
  output logic [7:0]           command_byte_out,
  output logic [7:0]           data_byte_out,
  input  logic [7:0]           data_byte_in,
  input  logic                 ack_in,
  input  logic                 data_valid_in
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT     = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  // Elaboration-time guard on the supported parameter range.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("i2c_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  // --------------------------------------------------------------------------
  // Unpack the flat per-requester buses into arrays for indexed selection.
  // --------------------------------------------------------------------------
  logic [6:0] addr_arr  [NUM_REQ];
  logic [7:0] cmd_arr   [NUM_REQ];
  logic [7:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr_in[7*gi +: 7];
    assign cmd_arr[gi]   = cmd_in[8*gi +: 8];
    assign wdata_arr[gi] = wdata_in[8*gi +: 8];
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t             state_q,      state_d;
  logic [NUM_REQ-1:0] grant_q,      grant_d;
  logic [IDX_W-1:0]   owner_q,      owner_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [6:0]         addr_q,       addr_d;
  logic               rw_q,         rw_d;
  logic [7:0]         cmd_q,        cmd_d;
  logic [7:0]         wdata_q,      wdata_d;
  logic [7:0]         rdata_q,      rdata_d;
  logic               ack_q,        ack_d;

  // --------------------------------------------------------------------------
  // Round-robin winner: the lowest requesting index strictly above
  // last_grant takes priority; if none, wrap and take the lowest requesting
  // index overall. The loops run high-to-low so the lowest index is the last
  // assignment and therefore wins.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] winner_lo;
  logic [IDX_W-1:0] winner_hi;
  logic             found_hi;
  logic [IDX_W-1:0] winner;

  always_comb begin
    winner_lo = '0;
    winner_hi = '0;
    found_hi  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        winner_lo = IDX_W'(i);
        if (i > int'(last_grant_q)) begin
          winner_hi = IDX_W'(i);
          found_hi  = 1'b1;
        end
      end
    end
    winner = found_hi ? winner_hi : winner_lo;
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Watchdog counter: cleared on the way into WAIT, counts WAIT cycles.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = ack_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|req_in) begin
          // Capture the winner's request once; the controller outputs then
          // stay frozen for the whole transaction even if the requester
          // changes its inputs or drops its request.
          owner_d = winner;
          grant_d = NUM_REQ'(1) << winner;
          addr_d  = addr_arr[winner];
          rw_d    = rw_in[winner];
          cmd_d   = cmd_arr[winner];
          wdata_d = wdata_arr[winner];
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (data_valid_in) begin
          rdata_d = data_byte_in;
          ack_d   = ack_in;
`ifdef I2C_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_COMPLETE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = 8'h00;
          ack_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_COMPLETE: begin
        last_grant_d = owner_q;
        grant_d      = '0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      // Starting from the top index makes requester 0 the first winner.
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      addr_q       <= '0;
      rw_q         <= 1'b0;
      cmd_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs. start/done/busy decode directly from the state register, so the
  // asynchronous reset clears them immediately along with the state.
  // --------------------------------------------------------------------------
  assign start_out           = (state_q == S_ISSUE);
  assign done_out            = (state_q == S_COMPLETE) ? grant_q : '0;
  assign busy_out            = (state_q != S_IDLE);
  assign grant_out           = grant_q;
  assign peripheral_addr_out = addr_q;
  assign rw_out              = rw_q;
  assign command_byte_out    = cmd_q;
  assign data_byte_out       = wdata_q;
  assign rdata_out           = rdata_q;
  assign ack_out             = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Purpose  : Scoreboard bench for i2c_bus_arbiter (default build). Stimulus
//            pushes expected issue/completion records into queues; a monitor
//            pops and compares them whenever the DUT shows start_out or a
//            done pulse. A small controller model answers each start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;

  localparam int NR = 4;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [NR-1:0]     req_in = '0;
  logic [7*NR-1:0]   addr_in = '0;
  logic [NR-1:0]     rw_in = '0;
  logic [8*NR-1:0]   cmd_in = '0;
  logic [8*NR-1:0]   wdata_in = '0;
  logic [NR-1:0]     grant_out;
  logic [NR-1:0]     done_out;
  logic [7:0]        rdata_out;
  logic              ack_out;
  logic              err_out;
  logic              busy_out;
  logic              start_out;
  logic [6:0]        peripheral_addr_out;
  logic              rw_out;
  logic [7:0]        command_byte_out;
  logic [7:0]        data_byte_out;
  logic [7:0]        data_byte_in;
  logic              ack_in;
  logic              data_valid_in;

  // Controller model drives dv_emu; the idle-pulse test drives dv_idle.
  logic       dv_emu = 1'b0, dv_idle = 1'b0, emu_ack = 1'b0;
  logic [7:0] emu_data = '0, idle_data = '0;
  assign data_valid_in = dv_emu | dv_idle;
  assign data_byte_in  = dv_idle ? idle_data : emu_data;
  assign ack_in        = emu_ack;

  i2c_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .addr_in(addr_in),
    .rw_in(rw_in), .cmd_in(cmd_in), .wdata_in(wdata_in),
    .grant_out(grant_out), .done_out(done_out), .rdata_out(rdata_out),
    .ack_out(ack_out), .err_out(err_out), .busy_out(busy_out),
    .start_out(start_out), .peripheral_addr_out(peripheral_addr_out),
    .rw_out(rw_out), .command_byte_out(command_byte_out),
    .data_byte_out(data_byte_out), .data_byte_in(data_byte_in),
    .ack_in(ack_in), .data_valid_in(data_valid_in)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] grant;
    logic [6:0]    addr;
    logic          rw;
    logic [7:0]    cmd;
    logic [7:0]    wdata;
    int            cyc;
  } iss_t;

  typedef struct {
    iss_t          tx;
    logic [7:0]    rdata;
    logic          ack;
    int            cyc;
  } done_t;

  iss_t  iss_q[$];
  done_t done_q[$];

  // Reference model state
  int         m_last = NR - 1;
  iss_t       m_cur;
  logic [7:0] m_rdata = '0;

  // Controller model knobs
  bit resp_hold   = 1'b0;
  int fixed_delay = 0;    // 0 = random 1..10
  int force_data  = -1;
  int force_ack   = -1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic abort(input string name);
    checks++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  // Round-robin rule: first requesting index after the last winner, wrapping.
  function automatic int rr_model(input logic [NR-1:0] mask, input int last);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (mask[idx]) return idx;
    end
    return last;
  endfunction

  function automatic logic [63:0] all_outs();
    return {20'h0, grant_out, done_out, start_out, rdata_out, ack_out, err_out,
            busy_out, rw_out, peripheral_addr_out, command_byte_out, data_byte_out};
  endfunction

  // --------------------------------------------------------------------------
  // Controller model: answer each start after 1..10 WAIT cycles.
  // --------------------------------------------------------------------------
  always @(negedge clk_in) begin
    if (start_out && !rst_in && !resp_hold) begin
      int d;
      done_t e;
      d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 10));
      repeat (d) @(negedge clk_in);
      emu_data = (force_data >= 0) ? force_data[7:0] : 8'($urandom);
      emu_ack  = (force_ack >= 0) ? force_ack[0] : 1'($urandom);
      dv_emu   = 1'b1;
      e.tx     = m_cur;
      e.rdata  = emu_data;
      e.ack    = emu_ack;
      e.cyc    = cyc + 1;
      m_rdata  = emu_data;
      done_q.push_back(e);
      @(negedge clk_in);
      dv_emu   = 1'b0;
      emu_data = 8'($urandom);
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if ($countones(grant_out) > 1) check("grant_onehot", grant_out, 0);
      if (start_out) begin
        if (iss_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          iss_t e;
          e = iss_q.pop_front();
          check("start_latency", cyc, e.cyc);
          check("grant", grant_out, e.grant);
          check("addr", peripheral_addr_out, e.addr);
          check("rw", rw_out, e.rw);
          check("cmd", command_byte_out, e.cmd);
          check("wdata", data_byte_out, e.wdata);
        end
      end
      if (done_out != '0) begin
        if (done_q.size() == 0) check("unexpected_done", done_out, 0);
        else begin
          done_t e;
          e = done_q.pop_front();
          check("done_latency", cyc, e.cyc);
          check("done_mask", done_out, e.tx.grant);
          check("rdata", rdata_out, e.rdata);
          check("ack", ack_out, e.ack);
          check("err", err_out, 0);
          check("stable_outs", {peripheral_addr_out, rw_out, command_byte_out, data_byte_out},
                {e.tx.addr, e.tx.rw, e.tx.cmd, e.tx.wdata});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk_in);
    while (busy_out) begin
      @(negedge clk_in);
      n++;
      if (n > 60) abort("idle_timeout");
    end
  endtask

  task automatic randomize_slices();
    addr_in  = 28'($urandom);
    rw_in    = 4'($urandom);
    cmd_in   = $urandom;
    wdata_in = $urandom;
  endtask

  // Drive a request at an IDLE negedge and record what the arbiter must issue.
  task automatic issue_txn(input logic [NR-1:0] mask, output int w);
    req_in = mask;
    w = rr_model(mask, m_last);
    m_last = w;
    m_cur.grant = NR'(1) << w;
    m_cur.addr  = addr_in[7*w +: 7];
    m_cur.rw    = rw_in[w];
    m_cur.cmd   = cmd_in[8*w +: 8];
    m_cur.wdata = wdata_in[8*w +: 8];
    m_cur.cyc   = cyc + 1;
    iss_q.push_back(m_cur);
  endtask

  task automatic do_txn(input logic [NR-1:0] mask, input bit hold, input bit drop,
                        input bit keep_data);
    int w;
    bit got;
    wait_idle();
    if (!keep_data) randomize_slices();
    issue_txn(mask, w);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (done_out != '0) begin
        got = 1'b1;
        break;
      end
      if (drop && i == 1) req_in[w] = 1'b0;
    end
    if (!got) abort("done_timeout");
    if (!hold) req_in = '0;
  endtask

  initial begin
    #2_000_000;
    abort("global_watchdog");
  end

  initial begin
    int w;
    // Reset state
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_outputs", all_outs(), 0);
    rst_in = 1'b0;

    // Directed write to requester 0, answered 10 cycles after start
    randomize_slices();
    addr_in[6:0]  = 7'h5A;
    rw_in[0]      = 1'b0;
    cmd_in[7:0]   = 8'h5E;
    wdata_in[7:0] = 8'h0C;
    fixed_delay = 10;
    force_ack   = 1;
    do_txn(4'b0001, 1'b0, 1'b0, 1'b1);
    check("directed_ack", ack_out, 1);

    // Directed read returning 0x24, then a stray data_valid while idle
    randomize_slices();
    rw_in[0]    = 1'b1;
    fixed_delay = 3;
    force_data  = 8'h24;
    do_txn(4'b0001, 1'b0, 1'b0, 1'b1);
    check("read_rdata", rdata_out, 8'h24);
    force_data = -1;
    force_ack  = -1;
    wait_idle();
    idle_data = 8'hA5;
    dv_idle   = 1'b1;
    @(negedge clk_in);
    dv_idle   = 1'b0;
    repeat (3) @(negedge clk_in);
    check("idle_dv_rdata", rdata_out, m_rdata);
    check("idle_dv_busy", busy_out, 0);

    // Requester drops its request mid-transaction
    fixed_delay = 5;
    do_txn(4'b0001, 1'b0, 1'b1, 1'b0);
    fixed_delay = 0;

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [NR-1:0] mask;
      mask = 4'($urandom_range(1, 15));
      do_txn(mask, 1'b0, ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Continuous single requester is regranted back to back
    for (int t = 0; t < 3; t++) do_txn(4'b0100, (t != 2), 1'b0, 1'b0);

    // Reset while waiting for a controller that never answers
    resp_hold = 1'b1;
    wait_idle();
    randomize_slices();
    issue_txn(4'($urandom_range(1, 15)), w);
    repeat (40) @(negedge clk_in);
    check("wait_unbounded_busy", busy_out, 1);
    check("wait_unbounded_err", err_out, 0);
    check("wait_owner", grant_out, m_cur.grant);
    #2 rst_in = 1'b1;
    #1 check("async_reset_outputs", all_outs(), 0);
    m_last  = NR - 1;
    m_rdata = '0;
    req_in  = '0;
    repeat (2) @(negedge clk_in);
    rst_in    = 1'b0;
    resp_hold = 1'b0;
    check("no_pending_issue", iss_q.size(), 0);
    check("no_pending_done", done_q.size(), 0);

    // All requesting, held: grants rotate 0,1,2,3,0 after reset
    for (int t = 0; t < 5; t++) do_txn(4'b1111, (t != 4), 1'b0, 1'b0);

    repeat (5) @(negedge clk_in);
    check("final_idle", busy_out, 0);
    check("final_queues_empty", iss_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, watchdog limit in clk_in cycles (used only under REQ-030).
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_in  input  NUM_REQ  per-requester transaction request, level, held until done.
REQ-006 SHALL have port addr_in  input  7*NUM_REQ  per-requester 7-bit peripheral address, slice i = [7i+6:7i].
REQ-007 SHALL have port rw_in  input  NUM_REQ  per-requester direction, 1 = read.
REQ-008 SHALL have port cmd_in  input  8*NUM_REQ  per-requester register/command byte.
REQ-009 SHALL have port wdata_in  input  8*NUM_REQ  per-requester write data byte.
REQ-010 SHALL have port grant_out  output  NUM_REQ  one-hot owner of the I2C controller.
REQ-011 SHALL have port done_out  output  NUM_REQ  one-cycle completion pulse to owner.
REQ-012 SHALL have port rdata_out  output  8  read byte of the last completed transaction.
REQ-013 SHALL have port ack_out  output  1  peripheral ACK of the last completed transaction.
REQ-014 SHALL have port err_out  output  1  last completed transaction timed out.
REQ-015 SHALL have port busy_out  output  1  high whenever state is not IDLE.
REQ-016 SHALL have ports start_out (1), peripheral_addr_out (7), rw_out (1), command_byte_out (8), data_byte_out (8)  outputs  toward the I2C controller.
REQ-017 SHALL have ports data_byte_in (8), ack_in (1), data_valid_in (1)  inputs  from the I2C controller.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, COMPLETE.
REQ-019 IDLE: if any req_in bit is set, SHALL select winner g round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap; SHALL register addr/rw/cmd/wdata slice g onto the controller outputs, set grant_out to one-hot g, and go to ISSUE.
REQ-020 ISSUE: SHALL assert start_out high for exactly this one cycle, then go to WAIT.
REQ-021 WAIT: on data_valid_in = 1, SHALL latch data_byte_in into rdata_out, ack_in into ack_out, clear err_out, and go to COMPLETE.
REQ-022 COMPLETE: SHALL pulse done_out[g] for one cycle, set last_grant = g, clear grant_out, return to IDLE.
REQ-023 Latency: request sampled in IDLE at cycle N -> start_out at N+1; data_valid_in at cycle M -> done_out at M+1; next grant no earlier than M+2.
REQ-024 Controller outputs (address, rw, command, data) SHALL remain stable from ISSUE until COMPLETE.
REQ-025 Requester dropping req_in mid-transaction SHALL NOT abort it; done still pulses.
REQ-026 data_valid_in outside WAIT SHALL be ignored.
REQ-027 Single requester continuously requesting SHALL be regranted after each completion; with all requesting, grants SHALL rotate 0,1,..,NUM_REQ-1,0.

Reset
REQ-028 On rst_in high, immediately and regardless of clock: state IDLE; grant_out, done_out, start_out, rdata_out, ack_out, err_out, busy_out, rw_out, peripheral_addr_out, command_byte_out, data_byte_out all 0; last_grant = NUM_REQ-1 (requester 0 first).
REQ-029 Reset mid-transaction SHALL abandon it without a done pulse; the I2C controller shares rst_in.

Configuration
REQ-030 With I2C_ARB_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT and increment each WAIT cycle; at TIMEOUT_CYCLES-1 without data_valid_in SHALL set err_out = 1, rdata_out = 0, ack_out = 0, go to COMPLETE. Without it: no counter, err_out constant 0, WAIT unbounded.

Verification
REQ-031 Reset release, req_in=0001, addr0=5A, rw0=0, cmd0=5E, wdata0=0C -> start_out one cycle later, outputs 5A/0/5E/0C, grant_out=0001; data_valid_in 10 cycles later with ack_in=1 -> done_out=0001 next cycle, ack_out=1.
REQ-032 req_in=1111 held, each transaction answered -> grant order 0,1,2,3,0; no two grant bits high ever.
REQ-033 Read, data_byte_in=24 with data_valid_in -> rdata_out=24 on done cycle; data_valid_in pulse in IDLE -> no done, rdata unchanged.
REQ-034 req0 dropped in WAIT -> transaction completes, done_out[0] still pulses once.
REQ-035 rst_in asserted in WAIT -> all outputs 0 asynchronously, no done; next grant goes to requester 0.
REQ-036 I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no data_valid_in -> done at WAIT entry +16, err_out=1, rdata_out=00; without macro -> stays in WAIT, err_out=0.
